dda_uart_link: RTL
==================

Name: dda_uart_link

Overview:
UART host link for the DDA solver tops: it decodes a byte-level command protocol into a writable parameter register file and streams framed solver-state snapshots back to the host. It sits between the UART core (byte-level rx/tx handshake) and the DDA core (flattened parameter bus, flattened state bus). It is generalised over word width, parameter count and state-variable count, and adds readback, run control and frame arbitration.

Parameters:
N, 16, word width in bits; multiple of 8; B = N/8 bytes per word
NUM_PARAMS, 7, number of N-bit parameter registers (max 256)
NUM_STATE, 3, number of N-bit state variables per frame
DEFAULTS, {7{16'h0000}}, NUM_PARAMS*N reset image; word k at bits [k*N +: N]
SYNC, 8'hA5, frame sync byte

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte
rx_byte  in  8  received byte
rx_error  in  1  one-cycle strobe: UART framing error
tx_start  out  1  one-cycle request to send tx_byte
tx_byte  out  8  byte to send; stable from tx_start until tx_busy falls
tx_busy  in  1  UART transmitter busy
state_in  in  NUM_STATE*N  solver state; variable k at [k*N +: N]
state_valid  in  1  one-cycle strobe: state_in updated
params  out  NUM_PARAMS*N  parameter bus to the DDA core
run  out  1  DDA enable
load_ic  out  1  one-cycle pulse: reload initial conditions
cmd_err  out  1  sticky; set by bad command/address/rx_error; cleared by 'C'
streaming  out  1  state streaming enabled

Behaviour:
- Reset (asynchronous, takes effect immediately, cancels any command or frame in flight): params=DEFAULTS, run=1, load_ic=0, streaming=0, cmd_err=0, tx_start=0, tx_byte=0, all FSMs idle.
- RX FSM states: IDLE, ADDR, DATA. Bytes are consumed only on rx_valid.
- IDLE decodes: 'W'(0x57)->ADDR(write); 'R'(0x52)->ADDR(read); 'S'(0x53) streaming=1; 'H'(0x48) streaming=0; 'G'(0x47) run=1; 'P'(0x50) run=0; 'I'(0x49) load_ic pulse, cycle after the byte; 'C'(0x43) cmd_err=0; any other byte sets cmd_err and stays IDLE.
- ADDR: latch addr. Write -> DATA. Read -> if addr<NUM_PARAMS post a read reply (copy of params[addr] taken this cycle), else set cmd_err; -> IDLE.
- DATA: collect B bytes MSB first into shift register; on B-th byte, if addr<NUM_PARAMS params[addr] updates next cycle (whole word atomically), else set cmd_err; -> IDLE. Partial words never reach params.
- rx_error in any state: set cmd_err, RX FSM -> IDLE, partial command discarded.
- Only one pending read reply: a read posted while one is pending overwrites it.
- TX FSM states: IDLE, SEND, WAIT. SEND asserts tx_start for exactly one cycle when tx_busy=0; the cycle after tx_start, tx_busy is ignored; then WAIT until tx_busy=0, then next byte or IDLE.
- Frame: on state_valid with streaming=1 and TX IDLE and no read pending, snapshot state_in; send SYNC then NUM_STATE*B bytes, variable 0 first, MSB first. state_valid during a frame or with TX busy is dropped (no queuing); snapshot is never updated mid-frame.
- Read reply: B bytes, MSB first, no sync byte. Arbitration at TX IDLE: pending read wins over a simultaneous state_valid; a read posted mid-frame is sent right after the frame ends.
- 'H' mid-frame: current frame completes; no new frames start.
- Write and simultaneous frame: snapshot and params are independent; write takes effect on schedule.
- Min latency: rx_valid of final byte of 'R' cmd -> tx_start 2 cycles later when TX idle.

Test Plan:
- Reset with DEFAULTS word3=16'h6A00 -> params[3*16+:16]=16'h6A00, run=1, streaming=0, tx_start never asserted without commands.
- Send 57 03 12 34 -> params word3=16'h1234 one cycle after last rx_valid; no other word changes; then 52 03 -> tx bytes 12, 34.
- Send 53, then state_valid with state_in={16'h0003,16'h0002,16'h0001} -> tx sequence A5 00 01 00 02 00 03; second state_valid mid-frame ignored (exactly 7 bytes).
- Send 57 09 AA BB (addr>=7) -> cmd_err=1, params unchanged; send 43 -> cmd_err=0; send 57 02 then rx_error -> cmd_err=1, word2 unchanged.
- Post 52 00 during a frame -> frame completes intact, reply bytes follow; simultaneous read and state_valid at idle -> reply first, frame dropped.
- Assert rst mid-frame and mid-write (after 57 01 AB) -> tx_start=0 immediately, params=DEFAULTS, next byte 34 treated as unknown command (cmd_err=1).

Source files
------------

// File: rtl/dda_uart_link_if.sv
// Byte-level rx/tx handshake between the UART core and the DDA host link.
interface dda_uart_link_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_error;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_busy;

   modport master (output rx_valid, rx_byte, rx_error, tx_busy,
                   input  tx_start, tx_byte);
   modport slave  (input  rx_valid, rx_byte, rx_error, tx_busy,
                   output tx_start, tx_byte);
endinterface

// File: rtl/dda_uart_link.sv
// UART host link for the DDA solver: command decoder into a parameter register
// file, plus framed state-snapshot streaming and parameter readback.
module dda_uart_link #(
   parameter int unsigned             N          = 16,
   parameter int unsigned             NUM_PARAMS = 7,
   parameter int unsigned             NUM_STATE  = 3,
   parameter logic [NUM_PARAMS*N-1:0] DEFAULTS   = '0,
   parameter logic [7:0]              SYNC       = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst,
   dda_uart_link_if.slave          bus,
   input  logic [NUM_STATE*N-1:0]  state_in,
   input  logic                    state_valid,
   output logic [NUM_PARAMS*N-1:0] params,
   output logic                    run,
   output logic                    load_ic,
   output logic                    cmd_err,
   output logic                    streaming
);
   localparam int unsigned B  = N / 8;
   localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;
   localparam int unsigned FB = 1 + NUM_STATE * B;
   localparam int unsigned FW = FB * 8;
   localparam int unsigned LW = $clog2(FB + 1);

   localparam logic [7:0] CMD_W = 8'h57, CMD_R = 8'h52, CMD_S = 8'h53, CMD_H = 8'h48;
   localparam logic [7:0] CMD_G = 8'h47, CMD_P = 8'h50, CMD_I = 8'h49, CMD_C = 8'h43;

   typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_DATA} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

   rx_state_t             rx_state_q, rx_state_nxt;
   logic                  is_rd_q, is_rd_nxt;
   logic [7:0]            addr_q, addr_nxt;
   logic [N-1:0]          wsh_q, wsh_nxt;
   logic [CW-1:0]         cnt_q, cnt_nxt;
   logic [NUM_PARAMS*N-1:0] params_q, params_nxt;
   logic                  run_q, run_nxt, load_ic_q, load_ic_nxt;
   logic                  cmd_err_q, cmd_err_nxt, streaming_q, streaming_nxt;
   logic                  rd_post_c;
   logic [N-1:0]          rd_word_c;

   tx_state_t             tx_state_q, tx_state_nxt;
   logic [FW-1:0]         tx_sh_q, tx_sh_nxt;
   logic [LW-1:0]         tx_left_q, tx_left_nxt;
   logic                  tx_start_q, tx_start_nxt;
   logic [7:0]            tx_byte_q, tx_byte_nxt;
   logic                  rd_pend_q, rd_pend_nxt;
   logic [N-1:0]          rd_data_q, rd_data_nxt;
   logic                  emit_c, frame_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q  <= RX_IDLE;
         is_rd_q     <= 1'b0;
         addr_q      <= '0;
         wsh_q       <= '0;
         cnt_q       <= '0;
         params_q    <= DEFAULTS;
         run_q       <= 1'b1;
         load_ic_q   <= 1'b0;
         cmd_err_q   <= 1'b0;
         streaming_q <= 1'b0;
         tx_state_q  <= TX_IDLE;
         tx_sh_q     <= '0;
         tx_left_q   <= '0;
         tx_start_q  <= 1'b0;
         tx_byte_q   <= '0;
         rd_pend_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rx_state_q  <= rx_state_nxt;
         is_rd_q     <= is_rd_nxt;
         addr_q      <= addr_nxt;
         wsh_q       <= wsh_nxt;
         cnt_q       <= cnt_nxt;
         params_q    <= params_nxt;
         run_q       <= run_nxt;
         load_ic_q   <= load_ic_nxt;
         cmd_err_q   <= cmd_err_nxt;
         streaming_q <= streaming_nxt;
         tx_state_q  <= tx_state_nxt;
         tx_sh_q     <= tx_sh_nxt;
         tx_left_q   <= tx_left_nxt;
         tx_start_q  <= tx_start_nxt;
         tx_byte_q   <= tx_byte_nxt;
         rd_pend_q   <= rd_pend_nxt;
         rd_data_q   <= rd_data_nxt;
      end
   end

   // Command decoder; rx_error overrides any byte and abandons the command.
   always_comb begin
      rx_state_nxt  = rx_state_q;
      is_rd_nxt     = is_rd_q;
      addr_nxt      = addr_q;
      wsh_nxt       = wsh_q;
      cnt_nxt       = cnt_q;
      params_nxt    = params_q;
      run_nxt       = run_q;
      load_ic_nxt   = 1'b0;
      cmd_err_nxt   = cmd_err_q;
      streaming_nxt = streaming_q;
      rd_post_c     = 1'b0;
      rd_word_c     = '0;
      if (bus.rx_error) begin
         cmd_err_nxt  = 1'b1;
         rx_state_nxt = RX_IDLE;
      end else if (bus.rx_valid) begin
         case (rx_state_q)
            RX_IDLE: begin
               case (bus.rx_byte)
                  CMD_W:   begin is_rd_nxt = 1'b0; rx_state_nxt = RX_ADDR; end
                  CMD_R:   begin is_rd_nxt = 1'b1; rx_state_nxt = RX_ADDR; end
                  CMD_S:   streaming_nxt = 1'b1;
                  CMD_H:   streaming_nxt = 1'b0;
                  CMD_G:   run_nxt = 1'b1;
                  CMD_P:   run_nxt = 1'b0;
                  CMD_I:   load_ic_nxt = 1'b1;
                  CMD_C:   cmd_err_nxt = 1'b0;
                  default: cmd_err_nxt = 1'b1;
               endcase
            end
            RX_ADDR: begin
               addr_nxt = bus.rx_byte;
               cnt_nxt  = '0;
               if (!is_rd_q) begin
                  rx_state_nxt = RX_DATA;
               end else begin
                  rx_state_nxt = RX_IDLE;
                  if (32'(bus.rx_byte) < NUM_PARAMS) begin
                     rd_post_c = 1'b1;
                     for (int unsigned k = 0; k < NUM_PARAMS; k++)
                        if (32'(bus.rx_byte) == k) rd_word_c = params_q[k*N +: N];
                  end else begin
                     cmd_err_nxt = 1'b1;
                  end
               end
            end
            RX_DATA: begin
               wsh_nxt = N'({wsh_q, bus.rx_byte});
               if (cnt_q == CW'(B - 1)) begin
                  rx_state_nxt = RX_IDLE;
                  if (32'(addr_q) < NUM_PARAMS) begin
                     for (int unsigned k = 0; k < NUM_PARAMS; k++)
                        if (32'(addr_q) == k) params_nxt[k*N +: N] = wsh_nxt;
                  end else begin
                     cmd_err_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt_q + CW'(1);
               end
            end
            default: rx_state_nxt = RX_IDLE;
         endcase
      end
   end

   // Transmit sequencer; a pending read reply takes priority over a new frame.
   always_comb begin
      tx_state_nxt = tx_state_q;
      tx_sh_nxt    = tx_sh_q;
      tx_left_nxt  = tx_left_q;
      tx_start_nxt = 1'b0;
      tx_byte_nxt  = tx_byte_q;
      rd_pend_nxt  = rd_pend_q;
      rd_data_nxt  = rd_data_q;
      emit_c       = 1'b0;
      frame_c      = state_valid && streaming_q && !rd_pend_q && !rd_post_c;
      case (tx_state_q)
         TX_IDLE: begin
            if (rd_pend_q) begin
               tx_sh_nxt            = '0;
               tx_sh_nxt[FW-1 -: N] = rd_data_q;
               tx_left_nxt          = LW'(B);
               rd_pend_nxt          = 1'b0;
               emit_c               = 1'b1;
            end else if (frame_c) begin
               tx_sh_nxt[FW-1 -: 8] = SYNC;
               for (int unsigned k = 0; k < NUM_STATE; k++)
                  tx_sh_nxt[FW-9-k*N -: N] = state_in[k*N +: N];
               tx_left_nxt = LW'(FB);
               emit_c      = 1'b1;
            end
         end
         TX_SEND: tx_state_nxt = TX_WAIT;
         TX_WAIT: begin
            if (!bus.tx_busy) begin
               if (tx_left_q != '0) emit_c = 1'b1;
               else                 tx_state_nxt = TX_IDLE;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
      // A freshly loaded job waits in WAIT if the UART is still busy.
      if (emit_c) begin
         if (bus.tx_busy) begin
            tx_state_nxt = TX_WAIT;
         end else begin
            tx_start_nxt = 1'b1;
            tx_byte_nxt  = tx_sh_nxt[FW-1 -: 8];
            tx_sh_nxt    = tx_sh_nxt << 8;
            tx_left_nxt  = tx_left_nxt - LW'(1);
            tx_state_nxt = TX_SEND;
         end
      end
      if (rd_post_c) begin
         rd_pend_nxt = 1'b1;
         rd_data_nxt = rd_word_c;
      end
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_byte  = tx_byte_q;
   assign params       = params_q;
   assign run          = run_q;
   assign load_ic      = load_ic_q;
   assign cmd_err      = cmd_err_q;
   assign streaming    = streaming_q;
endmodule
